estimate_seq: RTL and testbench

- Sequencer for the binarized conv/pool/norm/activation datapath (`estimate`).
- Generates its `com` / `addr` / `data` stream for one layer, 2x2 max-pool windows, 3x3 kernels, 32 channels per word.
- Reads activation words from an external activation buffer with 1-cycle registered read latency.
- Packs the per-output-channel `activ` results into one 32-bit word that feeds the next layer.

---
 rtl/estimate_pkg.sv | 16 +
 rtl/estimate_seq.sv | 128 ++++++++++++
 tb/tb_estimate_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/estimate_pkg.sv
// estimate_pkg: command codes, base addresses, defaults and FSM states for the estimate sequencer.
package estimate_pkg;
    localparam logic [2:0] CMD_INI   = 3'd0;
    localparam logic [2:0] CMD_ACC   = 3'd1;
    localparam logic [2:0] CMD_POOL  = 3'd2;
    localparam logic [2:0] CMD_NORM  = 3'd3;
    localparam logic [2:0] CMD_ACTIV = 3'd4;
    localparam logic [2:0] CMD_NOP   = 3'd7;
    localparam logic [15:0] W2_BASE = 16'd0;
    localparam logic [15:0] W3_BASE = 16'(9 * 32);
    localparam logic [15:0] M2_BASE = 16'(530 * 32);
    localparam logic [15:0] M3_BASE = 16'(531 * 32);
    localparam int NK_DEF    = 9;
    localparam int NPOOL_DEF = 4;
    typedef enum logic [2:0] {S_IDLE, S_INI, S_ACC, S_POOL, S_NORM, S_ACTIV} state_t;
endpackage

// File: rtl/estimate_seq.sv
// estimate_seq: issues the com/addr/data stream for one layer and packs the per-channel activ results.
module estimate_seq
    import estimate_pkg::*;
#(
    parameter int NOUT  = 32,
    parameter int NPOOL = NPOOL_DEF,
    parameter int NK    = NK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        layer,
    output logic        busy,
    output logic        done,
    output logic [31:0] out_word,
    output logic [5:0]  act_rd_addr,
    output logic        act_rd_en,
    input  logic [31:0] act_data,
    output logic [2:0]  com,
    output logic [15:0] addr,
    output logic [31:0] data,
    input  logic        activ
);
    localparam int PW = NPOOL > 1 ? $clog2(NPOOL) : 1;
    localparam int KW = NK > 1 ? $clog2(NK) : 1;

    state_t state, state_n;
    logic [4:0] oc, oc_n, cap_oc1, cap_oc2;
    logic [PW-1:0] p, p_n;
    logic [KW-1:0] k, k_n;
    logic [1:0] cap_v;
    logic layer_q, start_ok, last_cap;
    logic [2:0] com_n;
    logic [15:0] addr_n, wbase, mbase;

    // done and busy still hold for two cycles after the FSM returns to IDLE
    assign start_ok    = start && state == S_IDLE && !busy && !done;
    assign last_cap    = cap_v[1] && cap_oc2 == 5'(NOUT - 1);
    assign act_rd_en   = state == S_ACC;
    assign act_rd_addr = act_rd_en ? 6'(32'(p) * NK + 32'(k)) : 6'd0;
    assign data        = act_data;
    assign wbase       = layer_q ? W3_BASE : W2_BASE;
    assign mbase       = layer_q ? M3_BASE : M2_BASE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            oc    <= '0;
            p     <= '0;
            k     <= '0;
        end else begin
            state <= state_n;
            oc    <= oc_n;
            p     <= p_n;
            k     <= k_n;
        end
    end

    always_comb begin
        state_n = state;
        oc_n    = oc;
        p_n     = p;
        k_n     = k;
        case (state)
            S_IDLE: begin
                oc_n = '0;
                p_n  = '0;
                k_n  = '0;
                if (start_ok) state_n = S_INI;
            end
            S_INI: state_n = S_ACC;
            S_ACC: begin
                k_n = k == KW'(NK - 1) ? '0 : k + 1'b1;
                if (k == KW'(NK - 1)) state_n = S_POOL;
            end
            S_POOL: begin
                p_n     = p == PW'(NPOOL - 1) ? '0 : p + 1'b1;
                state_n = p == PW'(NPOOL - 1) ? S_NORM : S_ACC;
            end
            S_NORM: state_n = S_ACTIV;
            S_ACTIV: begin
                oc_n    = oc == 5'(NOUT - 1) ? '0 : oc + 5'd1;
                state_n = oc == 5'(NOUT - 1) ? S_IDLE : S_INI;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        com_n  = state == S_INI   ? CMD_INI   :
                 state == S_ACC   ? CMD_ACC   :
                 state == S_POOL  ? CMD_POOL  :
                 state == S_NORM  ? CMD_NORM  :
                 state == S_ACTIV ? CMD_ACTIV : CMD_NOP;
        addr_n = state == S_ACC  ? wbase + 16'(32'(oc) * NK) + 16'(k) :
                 state == S_NORM ? mbase + 16'(oc) : 16'd0;
    end

    // activ for an ACTIV slot settles two edges after it was decided; oc rides along
    always_ff @(posedge clk) begin
        if (reset) begin
            com      <= CMD_NOP;
            addr     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_word <= '0;
            layer_q  <= 1'b0;
            cap_v    <= '0;
            cap_oc1  <= '0;
            cap_oc2  <= '0;
        end else begin
            com     <= com_n;
            addr    <= addr_n;
            cap_v   <= {cap_v[0], state == S_ACTIV};
            cap_oc1 <= oc;
            cap_oc2 <= cap_oc1;
            done    <= last_cap;
            if (start_ok) begin
                busy     <= 1'b1;
                out_word <= '0;
                layer_q  <= layer;
            end else if (last_cap) begin
                busy <= 1'b0;
            end
            if (cap_v[1]) out_word[cap_oc2] <= ~activ;
        end
    end
endmodule

// File: tb/tb_estimate_seq.sv
// tb_estimate_seq: scoreboard bench with a loop-nest reference of the layer command stream.
module tb_estimate_seq;
    localparam int NOUT = 32;
    localparam int NK = 9;
    localparam int NPOOL = 4;

    typedef struct {
        int         cyc;
        logic [2:0] cm;
        logic [15:0] ad;
        int         idx;
    } ent_t;
    typedef struct {
        int          c;
        int          d;
        logic [31:0] w;
    } dn_t;

    logic clk = 1'b0;
    logic reset, start, layer;
    logic activ = 1'b0;
    logic [31:0] act_data = '0;
    logic busy, done, act_rd_en;
    logic [31:0] out_word, data;
    logic [5:0] act_rd_addr;
    logic [2:0] com;
    logic [15:0] addr;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int aidx = 0;
    int last_d;
    logic [31:0] mem [36];
    logic [31:0] bits = '0;
    ent_t cq[$];
    dn_t dq[$];

    estimate_seq #(.NOUT(NOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .layer(layer),
        .busy(busy), .done(done), .out_word(out_word),
        .act_rd_addr(act_rd_addr), .act_rd_en(act_rd_en), .act_data(act_data),
        .com(com), .addr(addr), .data(data), .activ(activ)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (act_rd_en) act_data <= mem[act_rd_addr];
    // datapath stub: each ACTIV command yields the next channel's chosen bit one edge later
    always @(posedge clk) begin
        if (reset) aidx <= 0;
        else if (com == 3'd4) begin
            activ <= bits[aidx];
            aidx  <= (aidx + 1) % NOUT;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic push_cmd(input int s, input logic [2:0] cm, input int a, input int idx);
        ent_t e;
        e.cyc = s;
        e.cm  = cm;
        e.ad  = 16'(a);
        e.idx = idx;
        cq.push_back(e);
    endtask

    // start accepted at the edge ending cycle c; slot i shows on com in cycle c+2+i
    task automatic push_run(input int c, input bit lay, input logic [31:0] b);
        int s = c + 2;
        int wb = lay ? 9 * 32 : 0;
        int mb = lay ? 531 * 32 : 530 * 32;
        dn_t d;
        for (int o = 0; o < NOUT; o++) begin
            push_cmd(s, 3'd0, 0, -1);
            s++;
            for (int pp = 0; pp < NPOOL; pp++) begin
                for (int kk = 0; kk < NK; kk++) begin
                    push_cmd(s, 3'd1, wb + o * NK + kk, pp * NK + kk);
                    s++;
                end
                push_cmd(s, 3'd2, 0, -1);
                s++;
            end
            push_cmd(s, 3'd3, mb + o, -1);
            s++;
            push_cmd(s, 3'd4, 0, -1);
            s++;
        end
        d.c = c;
        d.d = s + 1;
        d.w = ~b;
        dq.push_back(d);
        last_d = d.d;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
                chk("com", 32'(com), 32'(cq[0].cm));
                chk("addr", 32'(addr), 32'(cq[0].ad));
                if (cq[0].idx >= 0) chk("acc_data", data, mem[cq[0].idx]);
                void'(cq.pop_front());
            end else begin
                chk("idle_com", 32'(com), 32'd7);
            end
            chk("busy", 32'(busy), 32'(dq.size() > 0 && cyc > dq[0].c && cyc < dq[0].d));
            if (dq.size() > 0 && dq[0].d == cyc) begin
                chk("done", 32'(done), 32'd1);
                chk("out_word", out_word, dq[0].w);
                void'(dq.pop_front());
            end else begin
                chk("no_done", 32'(done), 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic launch(input bit lay, input logic [31:0] b);
        layer = lay;
        bits  = b;
        start = 1'b1;
        push_run(cyc, lay, b);
    endtask

    initial begin
        int x;
        reset = 1'b1;
        start = 1'b0;
        layer = 1'b0;
        for (int i = 0; i < 36; i++) mem[i] = $urandom;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_com", 32'(com), 32'd7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_rd_en", 32'(act_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(act_rd_addr), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        repeat (50) tick();
        chk("idle_out_word", out_word, 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // packing run on layer 2, with ignored starts mid-run and in the done cycle
        launch(1'b0, 32'hAAAA_AAAA);
        x = cyc;
        tick();
        start = 1'b0;
        layer = 1'b1;
        wait_until(x + 11);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(last_d);
        start = 1'b1;
        tick();
        launch(1'b1, $urandom);
        tick();
        start = 1'b0;
        layer = 1'b0;
        wait_until(last_d + 3);

        // reset in the middle of a run
        launch(1'($urandom), $urandom);
        x = cyc;
        tick();
        start = 1'b0;
        layer = 1'($urandom);
        wait_until(x + 1 + 500);
        reset = 1'b1;
        cq.delete();
        dq.delete();
        tick();
        chk("midrst_com", 32'(com), 32'd7);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (5) tick();

        // start held high: two back-to-back runs
        launch(1'($urandom), $urandom);
        tick();
        layer = 1'($urandom);
        wait_until(last_d);
        tick();
        launch(1'($urandom), $urandom);
        tick();
        layer = 1'($urandom);
        wait_until(last_d);
        start = 1'b0;
        repeat (6) tick();
        chk("queues_drained", 32'(cq.size() + dq.size()), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
